// File: rtl/hazard_pkg.sv
// Shared constants for the hazard scoreboard: forward-select encodings and default
// multiply/divide occupancy.
package hazard_pkg;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b01;
  localparam logic [1:0] FWD_W  = 2'b10;

  localparam int DEF_MUL_LAT = 5;
  localparam int DEF_DIV_LAT = 10;
endpackage

// File: rtl/mdu_busy_counter.sv
// Multiply/divide occupancy countdown. A new issue reloads the counter even while
// busy, and busy stays high for exactly the latency of the issued op.
module mdu_busy_counter
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int LAT_W   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);
  localparam logic [LAT_W-1:0] MUL_LD = LAT_W'(MUL_LAT);
  localparam logic [LAT_W-1:0] DIV_LD = LAT_W'(DIV_LAT);

  logic [LAT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (start) begin
      r_cnt <= is_div ? DIV_LD : MUL_LD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - LAT_W'(1);
    end
  end

  assign busy = (r_cnt != '0);
endmodule

// File: rtl/hazard_scoreboard.sv
// Five-stage pipeline hazard unit: D/E operand forwarding selects, load-use,
// branch-operand and mult/div stalls, plus a saturating stall-cycle counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int LAT_W   = 4,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic              use_rs_d,
  input  logic              use_rt_d,
  input  logic              br_d,
  input  logic              md_use_d,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] wr_reg_e,
  input  logic [REG_AW-1:0] wr_reg_m,
  input  logic [REG_AW-1:0] wr_reg_w,
  input  logic              reg_write_e,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic              mem_read_e,
  input  logic              mem_read_m,
  input  logic              md_start_e,
  input  logic              md_is_div_e,
  output logic [1:0]        fwd_a_d,
  output logic [1:0]        fwd_b_d,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_e,
  output logic              md_busy,
  output logic [PERF_W-1:0] stall_cycles
);
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic              m_ok,
    input logic [REG_AW-1:0] dst_m,
    input logic              we_m,
    input logic [REG_AW-1:0] dst_w,
    input logic              we_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != '0) begin
      if (m_ok && we_m && (src == dst_m)) begin
        sel = FWD_M;
      end else if (we_w && (src == dst_w)) begin
        sel = FWD_W;
      end
    end
    return sel;
  endfunction

  logic w_md_busy;
  logic w_match_e;
  logic w_match_m;
  logic w_load_stall;
  logic w_br_e_stall;
  logic w_br_m_stall;
  logic w_md_stall;
  logic w_stall;

  logic [PERF_W-1:0] r_stall_cycles;

  mdu_busy_counter #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .LAT_W   (LAT_W)
  ) u_busy (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start_e),
    .is_div (md_is_div_e),
    .busy   (w_md_busy)
  );

  // A load still in M has no data yet, so D-stage consumers may only take W.
  assign fwd_a_d = fwd_sel(rs_d, !mem_read_m, wr_reg_m, reg_write_m, wr_reg_w, reg_write_w);
  assign fwd_b_d = fwd_sel(rt_d, !mem_read_m, wr_reg_m, reg_write_m, wr_reg_w, reg_write_w);
  assign fwd_a_e = fwd_sel(rs_e, 1'b1, wr_reg_m, reg_write_m, wr_reg_w, reg_write_w);
  assign fwd_b_e = fwd_sel(rt_e, 1'b1, wr_reg_m, reg_write_m, wr_reg_w, reg_write_w);

  assign w_match_e = (use_rs_d && (rs_d == wr_reg_e)) || (use_rt_d && (rt_d == wr_reg_e));
  assign w_match_m = (use_rs_d && (rs_d == wr_reg_m)) || (use_rt_d && (rt_d == wr_reg_m));

  assign w_load_stall = mem_read_e && reg_write_e && (wr_reg_e != '0) && w_match_e;
  assign w_br_e_stall = br_d && reg_write_e && (wr_reg_e != '0) && w_match_e;
  assign w_br_m_stall = br_d && mem_read_m && (wr_reg_m != '0) && w_match_m;
  assign w_md_stall   = md_use_d && (w_md_busy || md_start_e);

  assign w_stall = !reset && (w_load_stall || w_br_e_stall || w_br_m_stall || w_md_stall);

  assign stall_f = w_stall;
  assign stall_d = w_stall;
  assign flush_e = w_stall;
  assign md_busy = w_md_busy;

  // Saturating so long-running profiles never wrap back to small values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + PERF_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: vector table, directed multi-cycle sequences and a
// randomized run against an arithmetic reference model.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_reg_e, wr_reg_m, wr_reg_w;
  logic       use_rs_d, use_rt_d, br_d, md_use_d;
  logic       reg_write_e, reg_write_m, reg_write_w, mem_read_e, mem_read_m;
  logic       md_start_e, md_is_div_e;

  logic [1:0]  fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e;
  logic        stall_f, stall_d, flush_e, md_busy;
  logic [31:0] stall_cycles;

  logic [1:0]  fwd_a_d2, fwd_b_d2, fwd_a_e2, fwd_b_e2;
  logic        stall_f2, stall_d2, flush_e2, md_busy2;
  logic [3:0]  stall_cycles2;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d), .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
    .br_d(br_d), .md_use_d(md_use_d), .rs_e(rs_e), .rt_e(rt_e), .wr_reg_e(wr_reg_e),
    .wr_reg_m(wr_reg_m), .wr_reg_w(wr_reg_w), .reg_write_e(reg_write_e), .reg_write_m(reg_write_m),
    .reg_write_w(reg_write_w), .mem_read_e(mem_read_e), .mem_read_m(mem_read_m),
    .md_start_e(md_start_e), .md_is_div_e(md_is_div_e), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .md_busy(md_busy), .stall_cycles(stall_cycles)
  );

  hazard_scoreboard #(.PERF_W(4)) dut4 (
    .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d), .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
    .br_d(br_d), .md_use_d(md_use_d), .rs_e(rs_e), .rt_e(rt_e), .wr_reg_e(wr_reg_e),
    .wr_reg_m(wr_reg_m), .wr_reg_w(wr_reg_w), .reg_write_e(reg_write_e), .reg_write_m(reg_write_m),
    .reg_write_w(reg_write_w), .mem_read_e(mem_read_e), .mem_read_m(mem_read_m),
    .md_start_e(md_start_e), .md_is_div_e(md_is_div_e), .fwd_a_d(fwd_a_d2), .fwd_b_d(fwd_b_d2),
    .fwd_a_e(fwd_a_e2), .fwd_b_e(fwd_b_e2), .stall_f(stall_f2), .stall_d(stall_d2), .flush_e(flush_e2),
    .md_busy(md_busy2), .stall_cycles(stall_cycles2)
  );

  typedef struct {
    logic [4:0] rs_d, rt_d;
    logic       urs, urt, br, mdu;
    logic [4:0] rs_e, rt_e, wr_e, wr_m, wr_w;
    logic       rwe, rwm, rww, mre, mrm;
    logic [1:0] xad, xbd, xae, xbe;
    logic       xst;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  int n_cmp  = 0;
  int n_fail = 0;

  // reference-model state: remaining busy cycles and stall counts
  int     m_busy;
  longint m_cnt;
  longint m_cnt4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_in();
    rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
    wr_reg_e = '0; wr_reg_m = '0; wr_reg_w = '0;
    use_rs_d = 0; use_rt_d = 0; br_d = 0; md_use_d = 0;
    reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
    mem_read_e = 0; mem_read_m = 0; md_start_e = 0; md_is_div_e = 0;
  endtask

  task automatic do_reset();
    tick(); reset = 1; clear_in();
    tick(); tick(); reset = 0;
  endtask

  task automatic chk_stall(input string name, input logic exp);
    chk({name, "_stall_f"}, 32'(stall_f), 32'(exp));
    chk({name, "_stall_d"}, 32'(stall_d), 32'(exp));
    chk({name, "_flush_e"}, 32'(flush_e), 32'(exp));
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] src, input logic m_ok);
    if (src == 0) return 2'd0;
    if (m_ok && reg_write_m && src == wr_reg_m) return 2'd1;
    if (reg_write_w && src == wr_reg_w) return 2'd2;
    return 2'd0;
  endfunction

  initial begin
    // rs_d rt_d urs urt br mdu | rs_e rt_e wr_e wr_m wr_w | rwe rwm rww mre mrm | xad xbd xae xbe xst
    tbl[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 5'd0, 5'd0, 5'd8, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0};
    tbl[1]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 5'd0, 5'd0, 5'd8, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0};
    tbl[2]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd8, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
    tbl[3]  = '{5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 2'd2, 1'b0};
    tbl[4]  = '{5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0};
    tbl[5]  = '{5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 2'd0, 2'd1, 2'd0, 1'b0};
    tbl[6]  = '{5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1};
    tbl[7]  = '{5'd0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
    tbl[8]  = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
    tbl[9]  = '{5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1};
    tbl[10] = '{5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1};
    tbl[11] = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
    tbl[12] = '{5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
    tbl[13] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
    tbl[14] = '{5'd0, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1};
    tbl[15] = '{5'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0, 5'd3, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0, 2'd1, 1'b0};

    // Reset: stalls forced low, forwarding still live, state cleared
    reset = 1; clear_in();
    tick(); tick();
    mem_read_e = 1; reg_write_e = 1; wr_reg_e = 5'd9; rt_d = 5'd9; use_rt_d = 1;
    rs_e = 5'd8; wr_reg_m = 5'd8; reg_write_m = 1; md_use_d = 1; md_start_e = 1;
    #1;
    chk_stall("rst", 1'b0);
    chk("rst_fwd_a_e", 32'(fwd_a_e), 32'd1);
    chk("rst_md_busy", 32'(md_busy), 32'd0);
    chk("rst_stall_cycles", stall_cycles, 32'd0);
    tick(); reset = 0; clear_in();
    #1;
    chk("rst_start_ignored", 32'(md_busy), 32'd0);

    for (int i = 0; i < NV; i++) begin
      tick();
      rs_d = tbl[i].rs_d; rt_d = tbl[i].rt_d; use_rs_d = tbl[i].urs; use_rt_d = tbl[i].urt;
      br_d = tbl[i].br; md_use_d = tbl[i].mdu; rs_e = tbl[i].rs_e; rt_e = tbl[i].rt_e;
      wr_reg_e = tbl[i].wr_e; wr_reg_m = tbl[i].wr_m; wr_reg_w = tbl[i].wr_w;
      reg_write_e = tbl[i].rwe; reg_write_m = tbl[i].rwm; reg_write_w = tbl[i].rww;
      mem_read_e = tbl[i].mre; mem_read_m = tbl[i].mrm; md_start_e = 0; md_is_div_e = 0;
      #1;
      chk($sformatf("tbl%0d_fwd_a_d", i), 32'(fwd_a_d), 32'(tbl[i].xad));
      chk($sformatf("tbl%0d_fwd_b_d", i), 32'(fwd_b_d), 32'(tbl[i].xbd));
      chk($sformatf("tbl%0d_fwd_a_e", i), 32'(fwd_a_e), 32'(tbl[i].xae));
      chk($sformatf("tbl%0d_fwd_b_e", i), 32'(fwd_b_e), 32'(tbl[i].xbe));
      chk_stall($sformatf("tbl%0d", i), tbl[i].xst);
    end

    // V2: load-use stalls exactly one cycle
    do_reset(); tick();
    mem_read_e = 1; reg_write_e = 1; wr_reg_e = 5'd9; rt_d = 5'd9; use_rt_d = 1;
    #1; chk_stall("v2_c0", 1'b1);
    tick();
    mem_read_e = 0; reg_write_e = 0; wr_reg_e = 0;
    mem_read_m = 1; reg_write_m = 1; wr_reg_m = 5'd9;
    #1; chk_stall("v2_c1", 1'b0);
    chk("v2_c1_fwd_b_d", 32'(fwd_b_d), 32'd0);
    chk("v2_cnt", stall_cycles, 32'd1);
    tick(); clear_in();
    mem_read_e = 1; reg_write_e = 1; wr_reg_e = 5'd9; rt_d = 5'd9; use_rt_d = 0;
    #1; chk_stall("v2_nouse", 1'b0);

    // V3: branch operand behind an ALU op, then a load in M, then resolved from W
    do_reset(); tick();
    br_d = 1; rs_d = 5'd4; use_rs_d = 1; reg_write_e = 1; wr_reg_e = 5'd4;
    #1; chk_stall("v3_e", 1'b1);
    tick(); reg_write_e = 0; wr_reg_e = 0; reg_write_m = 1; wr_reg_m = 5'd4; mem_read_m = 1;
    #1; chk_stall("v3_m", 1'b1);
    chk("v3_m_fwd_a_d", 32'(fwd_a_d), 32'd0);
    tick(); reg_write_m = 0; wr_reg_m = 0; mem_read_m = 0; reg_write_w = 1; wr_reg_w = 5'd4;
    #1; chk_stall("v3_w", 1'b0);
    chk("v3_w_fwd_a_d", 32'(fwd_a_d), 32'd2);

    // V4: divide with dependent HI/LO user stalls start cycle + DIV_LAT
    do_reset(); tick();
    md_use_d = 1; md_start_e = 1; md_is_div_e = 1;
    #1; chk_stall("v4_k0", 1'b1);
    for (int k = 1; k <= 12; k++) begin
      tick(); md_start_e = 0; md_is_div_e = 0;
      #1;
      chk($sformatf("v4_k%0d_stall_d", k), 32'(stall_d), 32'(k <= 10));
      chk($sformatf("v4_k%0d_md_busy", k), 32'(md_busy), 32'(k <= 10));
      if (k == 11) begin
        chk("v4_cnt", stall_cycles, 32'd11);
        chk("v4_cnt4", 32'(stall_cycles2), 32'd11);
      end
    end

    // Multiply: busy for exactly MUL_LAT cycles after issue
    do_reset(); tick();
    md_start_e = 1; md_is_div_e = 0;
    #1; chk("mul_k0_busy", 32'(md_busy), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      tick(); md_start_e = 0;
      #1; chk($sformatf("mul_k%0d_busy", k), 32'(md_busy), 32'(k <= 5));
    end

    // V5: reset aborts a divide at busy_cnt=3
    do_reset(); tick();
    md_use_d = 1; md_start_e = 1; md_is_div_e = 1;
    for (int k = 1; k <= 8; k++) begin
      tick(); md_start_e = 0;
    end
    reset = 1;
    #1;
    chk("v5_pre_busy", 32'(md_busy), 32'd1);
    chk("v5_pre_cnt", stall_cycles, 32'd8);
    chk_stall("v5_in_rst", 1'b0);
    tick(); reset = 0;
    #1;
    chk("v5_busy", 32'(md_busy), 32'd0);
    chk("v5_cnt", stall_cycles, 32'd0);
    chk_stall("v5_after", 1'b0);

    // V6: saturation of the narrow counter
    do_reset(); tick();
    mem_read_e = 1; reg_write_e = 1; wr_reg_e = 5'd9; rt_d = 5'd9; use_rt_d = 1;
    for (int k = 0; k <= 23; k++) begin
      if (k > 0) tick();
      #1;
      if (k == 20 || k == 23) begin
        chk($sformatf("v6_k%0d_cnt4", k), 32'(stall_cycles2), 32'd15);
        chk($sformatf("v6_k%0d_cnt", k), stall_cycles, 32'(k));
      end
    end

    // Randomized run against the reference model
    do_reset();
    m_busy = 0; m_cnt = 0; m_cnt4 = 0;
    for (int c = 0; c < 600; c++) begin
      logic mt_e, mt_m, e_st;
      tick();
      reset       = ($urandom_range(0, 39) == 0);
      rs_d        = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
      rs_e        = 5'($urandom_range(0, 3)); rt_e = 5'($urandom_range(0, 3));
      wr_reg_e    = 5'($urandom_range(0, 3)); wr_reg_m = 5'($urandom_range(0, 3));
      wr_reg_w    = 5'($urandom_range(0, 3));
      use_rs_d    = 1'($urandom_range(0, 1)); use_rt_d = 1'($urandom_range(0, 1));
      br_d        = ($urandom_range(0, 3) == 0);
      md_use_d    = ($urandom_range(0, 2) == 0);
      reg_write_e = 1'($urandom_range(0, 1)); reg_write_m = 1'($urandom_range(0, 1));
      reg_write_w = 1'($urandom_range(0, 1));
      mem_read_e  = ($urandom_range(0, 2) == 0); mem_read_m = ($urandom_range(0, 2) == 0);
      md_start_e  = ($urandom_range(0, 7) == 0); md_is_div_e = 1'($urandom_range(0, 1));
      #1;
      mt_e = (use_rs_d && rs_d == wr_reg_e) || (use_rt_d && rt_d == wr_reg_e);
      mt_m = (use_rs_d && rs_d == wr_reg_m) || (use_rt_d && rt_d == wr_reg_m);
      e_st = !reset && ((mem_read_e && reg_write_e && wr_reg_e != 0 && mt_e) ||
                        (br_d && reg_write_e && wr_reg_e != 0 && mt_e) ||
                        (br_d && mem_read_m && wr_reg_m != 0 && mt_m) ||
                        (md_use_d && (m_busy > 0 || md_start_e)));
      chk("rnd_fwd_a_d", 32'(fwd_a_d), 32'(ref_fwd(rs_d, !mem_read_m)));
      chk("rnd_fwd_b_d", 32'(fwd_b_d), 32'(ref_fwd(rt_d, !mem_read_m)));
      chk("rnd_fwd_a_e", 32'(fwd_a_e), 32'(ref_fwd(rs_e, 1'b1)));
      chk("rnd_fwd_b_e", 32'(fwd_b_e), 32'(ref_fwd(rt_e, 1'b1)));
      chk_stall("rnd", e_st);
      chk("rnd_md_busy", 32'(md_busy), 32'(m_busy > 0));
      chk("rnd_cnt", stall_cycles, 32'(m_cnt));
      chk("rnd_cnt4", 32'(stall_cycles2), 32'(m_cnt4));
      if (reset) begin
        m_busy = 0; m_cnt = 0; m_cnt4 = 0;
      end else begin
        if (md_start_e) m_busy = md_is_div_e ? 10 : 5;
        else if (m_busy > 0) m_busy = m_busy - 1;
        if (e_st) begin
          if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
          if (m_cnt4 < 15) m_cnt4 = m_cnt4 + 1;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter MUL_LAT, default 5, multiply busy cycles (1..2^LAT_W-1).
REQ-003 SHALL have parameter DIV_LAT, default 10, divide busy cycles (1..2^LAT_W-1).
REQ-004 SHALL have parameter LAT_W, default 4, busy-counter width.
REQ-005 SHALL have parameter PERF_W, default 32, stall-counter width.
REQ-006 Ports, one per line, name direction width meaning:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- rs_d, rt_d  in  REG_AW  D-stage source registers.
- use_rs_d, use_rt_d  in  1  D instruction actually reads rs/rt.
- br_d  in  1  D instruction is a branch or jr and compares/uses its operands in D.
- md_use_d  in  1  D instruction reads or writes HI/LO, or starts mult/div.
- rs_e, rt_e  in  REG_AW  E-stage source registers.
- wr_reg_e, wr_reg_m, wr_reg_w  in  REG_AW  destination register per stage.
- reg_write_e, reg_write_m, reg_write_w  in  1  stage writes its destination.
- mem_read_e, mem_read_m  in  1  stage holds a load.
- md_start_e  in  1  mult/div issues from E this cycle.
- md_is_div_e  in  1  the issuing op is a divide.
- fwd_a_d, fwd_b_d  out  2  D-stage operand select for rs/rt.
- fwd_a_e, fwd_b_e  out  2  E-stage operand select for rs/rt.
- stall_f, stall_d  out  1  hold PC / hold IF-ID register; active-high.
- flush_e  out  1  insert bubble into ID-EX.
- md_busy  out  1  multiply/divide unit busy.
- stall_cycles  out  PERF_W  stall-cycle count.

Function
REQ-007 Forward encoding SHALL be 00 register file, 01 from M, 10 from W; 11 SHALL never be driven.
REQ-008 fwd_a_e SHALL be 01 if rs_e!=0 && rs_e==wr_reg_m && reg_write_m; else 10 if rs_e!=0 && rs_e==wr_reg_w && reg_write_w; else 00. fwd_b_e uses rt_e the same way. M SHALL take priority over W.
REQ-009 fwd_a_d / fwd_b_d SHALL follow the same M-over-W rule using rs_d / rt_d, except M SHALL NOT be selected when mem_read_m=1.
REQ-010 load_stall SHALL be mem_read_e && reg_write_e && wr_reg_e!=0 && ((use_rs_d && rs_d==wr_reg_e) || (use_rt_d && rt_d==wr_reg_e)).
REQ-011 br_e_stall SHALL be br_d && reg_write_e && wr_reg_e!=0 && a matching used operand (same match term as REQ-010).
REQ-012 br_m_stall SHALL be br_d && mem_read_m && wr_reg_m!=0 && a used operand matching wr_reg_m.
REQ-013 md_stall SHALL be md_use_d && (busy_cnt!=0 || md_start_e).
REQ-014 stall_f, stall_d and flush_e SHALL all equal the OR of REQ-010..013, combinationally in the same cycle.
REQ-015 The busy counter SHALL operate as follows:
- Register busy_cnt, LAT_W bits.
- On md_start_e: load DIV_LAT if md_is_div_e, else MUL_LAT. Reload SHALL win even if busy_cnt!=0.
- Otherwise, if busy_cnt!=0: decrement.
- Otherwise: hold 0.
REQ-016 md_busy SHALL be (busy_cnt!=0), registered. The first cycle after a MUL_LAT=5 start through the fifth SHALL read 1.
REQ-017 stall_cycles SHALL increment each cycle stall_d=1, SHALL saturate at all-ones, and SHALL never wrap.
REQ-018 Register 0 SHALL never cause forwarding or stalls, regardless of write enables.

Reset
REQ-019 While reset=1, on each rising edge busy_cnt and stall_cycles SHALL be cleared to 0; md_busy SHALL read 0 the following cycle.
REQ-020 While reset=1, stall_f, stall_d and flush_e SHALL be forced 0. Forwarding outputs SHALL remain combinational.
REQ-021 Reset SHALL abort an in-flight mult/div countdown; md_start_e during reset SHALL be ignored.

Structure
REQ-022 Shared package hazard_pkg SHALL hold:
- FWD_RF / FWD_M / FWD_W constants.
- Default MUL_LAT / DIV_LAT.
REQ-023 Busy countdown SHALL be one sub-module mdu_busy_counter (ports: clk, reset, start, is_div, busy). The remaining logic SHALL be flat in hazard_scoreboard.

Verification
REQ-024 Bench SHALL cover these directed scenarios:
- V1: wr_reg_m=8, reg_write_m=1; wr_reg_w=8, reg_write_w=1; rs_e=8 -> fwd_a_e=01. Drop reg_write_m -> 10. Set rs_e=0 -> 00.
- V2: load in E with wr_reg_e=9; rt_d=9, use_rt_d=1 -> stall_f=stall_d=flush_e=1 for exactly one cycle. Same stimulus with use_rt_d=0 -> no stall.
- V3: beq in D with rs_d=4; ALU writing 4 in E -> 1 stall. Then the same instruction in M with mem_read_m=1 -> 2nd stall. Then in W -> fwd_a_d=10, no stall.
- V4: md_start_e with md_is_div_e=1 (DIV_LAT=10); md_use_d held -> stall for 11 consecutive cycles (start cycle + 10). stall_cycles=11 afterwards.
- V5: reset asserted at busy_cnt=3 -> next cycle md_busy=0 and stall_cycles=0; md_use_d causes no stall.
- V6: PERF_W=4, stall held 20 cycles -> stall_cycles=15, stays at 15.
